// File: rtl/memory_store_buffer_pkg.sv
// rtl/memory_store_buffer_pkg.sv - shared constants and entry type for the store buffer
//
// Contents:
//   STORE_BUFFER_XLEN  - default data/address width
//   STORE_BUFFER_DEPTH - default entry count (power of two, >= 2)
//   storeBufferEntry_  - {valid, address, data, byteEnable} at the default width
//   store_buffer_index_width - index width for a given depth
package memory_store_buffer_pkg;

    localparam int STORE_BUFFER_XLEN  = 32;
    localparam int STORE_BUFFER_DEPTH = 4;

    typedef struct packed {
        logic                             valid;
        logic [STORE_BUFFER_XLEN-1:0]     address;
        logic [STORE_BUFFER_XLEN-1:0]     data;
        logic [STORE_BUFFER_XLEN/8-1:0]   byteEnable;
    } storeBufferEntry_;

    function automatic int store_buffer_index_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/memory_store_buffer_match.sv
// rtl/memory_store_buffer_match.sv - combinational load-versus-buffered-store compare
//
// Build option: STORE_FORWARD_EN enables youngest-covering-entry selection.
// Ports:
//   entryValid/entryAddress/entryByteEnable - per-entry buffer state
//   headIndex       - index of the oldest entry; scanning starts here
//   loadAddress     - load byte address
//   loadByteEnable  - lane-shifted load byte enables
//   match           - per-entry hit: valid, same word, overlapping lanes
//   forwardHit      - youngest hit covers every load lane (0 without the option)
//   forwardIndex    - index of that youngest hit (0 without the option)
import memory_store_buffer_pkg::*;

module store_buffer_match #(
    parameter int XLEN  = STORE_BUFFER_XLEN,
    parameter int DEPTH = STORE_BUFFER_DEPTH
) (
    input  logic [DEPTH-1:0]                 entryValid,
    input  logic [DEPTH-1:0][XLEN-1:0]       entryAddress,
    input  logic [DEPTH-1:0][XLEN/8-1:0]     entryByteEnable,
    input  logic [$clog2(DEPTH)-1:0]         headIndex,
    input  logic [XLEN-1:0]                  loadAddress,
    input  logic [XLEN/8-1:0]                loadByteEnable,
    output logic [DEPTH-1:0]                 match,
    output logic                             forwardHit,
    output logic [$clog2(DEPTH)-1:0]         forwardIndex
);

    localparam int IW = store_buffer_index_width(DEPTH);
    localparam int OW = $clog2(XLEN/8);

    // Byte offset bits never take part in the compare; lanes are handled by the enables.
    logic unused_offsets;
    always_comb begin
        unused_offsets = ^loadAddress[OW-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            unused_offsets = unused_offsets ^ (^entryAddress[i][OW-1:0]);
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entryValid[i]
                    && (entryAddress[i][XLEN-1:OW] == loadAddress[XLEN-1:OW])
                    && (|(entryByteEnable[i] & loadByteEnable));
        end
    end

`ifdef STORE_FORWARD_EN
    logic [IW-1:0] scanIndex;
    logic [IW-1:0] youngestIndex;
    logic          youngestFound;

    // Walk from oldest to youngest so the last hit seen is the youngest.
    // Only the youngest can forward: if it misses a load lane, an older
    // entry (or memory) would have to supply that lane, so the load stalls.
    always_comb begin
        scanIndex     = '0;
        youngestIndex = '0;
        youngestFound = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            scanIndex = headIndex + IW'(k);
            if (match[scanIndex]) begin
                youngestFound = 1'b1;
                youngestIndex = scanIndex;
            end
        end
        forwardHit   = youngestFound
                    && ((entryByteEnable[youngestIndex] & loadByteEnable) == loadByteEnable);
        forwardIndex = youngestIndex;
    end
`else
    logic unused_head;
    assign unused_head  = ^headIndex;
    assign forwardHit   = 1'b0;
    assign forwardIndex = '0;
`endif

endmodule

// File: rtl/memory_store_buffer.sv
// rtl/memory_store_buffer.sv - in-order store buffer with load hazard check
//
// Build option: STORE_FORWARD_EN enables store-to-load forwarding.
// Ports:
//   clock, reset                  - clock; synchronous active-high reset
//   enqValid/enqReady             - store enqueue handshake (enqReady = !full)
//   enqAddress/enqData/enqByteEnable - store being enqueued
//   storeValid/storeAddress/storeData/storeByteEnable - head entry offered to memory
//   storeComplete                 - memory accepted the head this cycle
//   loadCheckValid/loadCheckAddress/loadCheckByteEnable - load to check
//   loadHazard                    - load must stall
//   loadForwardValid/loadForwardData - forwarded word (0 without the option)
//   bufferEmpty                   - no entries held
import memory_store_buffer_pkg::*;

module memory_store_buffer #(
    parameter int XLEN  = STORE_BUFFER_XLEN,
    parameter int DEPTH = STORE_BUFFER_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enqValid,
    output logic                enqReady,
    input  logic [XLEN-1:0]     enqAddress,
    input  logic [XLEN-1:0]     enqData,
    input  logic [XLEN/8-1:0]   enqByteEnable,
    output logic                storeValid,
    output logic [XLEN-1:0]     storeAddress,
    output logic [XLEN-1:0]     storeData,
    output logic [XLEN/8-1:0]   storeByteEnable,
    input  logic                storeComplete,
    input  logic                loadCheckValid,
    input  logic [XLEN-1:0]     loadCheckAddress,
    input  logic [XLEN/8-1:0]   loadCheckByteEnable,
    output logic                loadHazard,
    output logic                loadForwardValid,
    output logic [XLEN-1:0]     loadForwardData,
    output logic                bufferEmpty
);

    localparam int IW = store_buffer_index_width(DEPTH);
    localparam int BW = XLEN / 8;

    logic [DEPTH-1:0]             entryValid;
    logic [DEPTH-1:0][XLEN-1:0]   entryAddress;
    logic [DEPTH-1:0][XLEN-1:0]   entryData;
    logic [DEPTH-1:0][BW-1:0]     entryByteEnable;

    // The extra top bit on the pointers is the wrap flag; indices are the low bits.
    logic [IW:0]   headPointer;
    logic [IW:0]   tailPointer;
    logic [IW:0]   count;
    logic [IW-1:0] headIndex;
    logic [IW-1:0] tailIndex;

    logic full;
    logic empty;
    logic enqFire;
    logic popFire;

    assign headIndex = headPointer[IW-1:0];
    assign tailIndex = tailPointer[IW-1:0];
    assign full      = (count == (IW+1)'(DEPTH));
    assign empty     = (count == '0);

    // No bypass when full: a pop in the same cycle does not open a slot until the next cycle.
    assign enqReady  = !full;
    assign enqFire   = enqValid && enqReady;
    assign popFire   = storeComplete && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            headPointer <= '0;
            tailPointer <= '0;
            count       <= '0;
            entryValid  <= '0;
        end else begin
            if (enqFire) begin
                entryValid[tailIndex]      <= 1'b1;
                entryAddress[tailIndex]    <= enqAddress;
                entryData[tailIndex]       <= enqData;
                entryByteEnable[tailIndex] <= enqByteEnable;
                tailPointer                <= tailPointer + 1'b1;
            end
            // A pop never targets the slot being written: that needs full, which blocks enqueue.
            if (popFire) begin
                entryValid[headIndex] <= 1'b0;
                headPointer           <= headPointer + 1'b1;
            end
            case ({enqFire, popFire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign storeValid      = !empty;
    assign storeAddress    = entryAddress[headIndex];
    assign storeData       = entryData[headIndex];
    assign storeByteEnable = entryByteEnable[headIndex];
    assign bufferEmpty     = empty;

    logic [DEPTH-1:0] match;
    logic             forwardHit;
    logic [IW-1:0]    forwardIndex;

    store_buffer_match #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_match (
        .entryValid      (entryValid),
        .entryAddress    (entryAddress),
        .entryByteEnable (entryByteEnable),
        .headIndex       (headIndex),
        .loadAddress     (loadCheckAddress),
        .loadByteEnable  (loadCheckByteEnable),
        .match           (match),
        .forwardHit      (forwardHit),
        .forwardIndex    (forwardIndex)
    );

    // A store enqueued this cycle is not yet in entryValid, so it is invisible
    // to a same-cycle load; a popping head is still valid, so it still hazards.
`ifdef STORE_FORWARD_EN
    assign loadForwardValid = loadCheckValid && forwardHit;
    assign loadForwardData  = loadForwardValid ? entryData[forwardIndex] : '0;
    assign loadHazard       = loadCheckValid && (|match) && !forwardHit;
`else
    logic unused_forward;
    assign unused_forward   = forwardHit ^ (^forwardIndex);
    assign loadForwardValid = 1'b0;
    assign loadForwardData  = '0;
    assign loadHazard       = loadCheckValid && (|match);
`endif

endmodule

// File: tb/tb_memory_store_buffer.sv
// tb/tb_memory_store_buffer.sv - self-checking bench for memory_store_buffer
import memory_store_buffer_pkg::*;

module tb_memory_store_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enqValid;
    logic              enqReady;
    logic [XLEN-1:0]   enqAddress;
    logic [XLEN-1:0]   enqData;
    logic [XLEN/8-1:0] enqByteEnable;
    logic              storeValid;
    logic [XLEN-1:0]   storeAddress;
    logic [XLEN-1:0]   storeData;
    logic [XLEN/8-1:0] storeByteEnable;
    logic              storeComplete;
    logic              loadCheckValid;
    logic [XLEN-1:0]   loadCheckAddress;
    logic [XLEN/8-1:0] loadCheckByteEnable;
    logic              loadHazard;
    logic              loadForwardValid;
    logic [XLEN-1:0]   loadForwardData;
    logic              bufferEmpty;

    always #5 clock = ~clock;

    memory_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .enqValid            (enqValid),
        .enqReady            (enqReady),
        .enqAddress          (enqAddress),
        .enqData             (enqData),
        .enqByteEnable       (enqByteEnable),
        .storeValid          (storeValid),
        .storeAddress        (storeAddress),
        .storeData           (storeData),
        .storeByteEnable     (storeByteEnable),
        .storeComplete       (storeComplete),
        .loadCheckValid      (loadCheckValid),
        .loadCheckAddress    (loadCheckAddress),
        .loadCheckByteEnable (loadCheckByteEnable),
        .loadHazard          (loadHazard),
        .loadForwardValid    (loadForwardValid),
        .loadForwardData     (loadForwardData),
        .bufferEmpty         (bufferEmpty)
    );

    int tests = 0;
    int fails = 0;
    logic overflowProbe = 1'b0;

    // Reference: program-ordered list of buffered stores, oldest first.
    storeBufferEntry_ model[$];

    typedef struct {
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  eb;
        logic        sc;
        logic        lv;
        logic [31:0] la;
        logic [3:0]  lb;
        logic        xsv;
        logic        xer;
        logic        xem;
        logic        xhz;
        logic [31:0] xsd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                                input logic [3:0] eb, input logic sc, input logic lv,
                                input logic [31:0] la, input logic [3:0] lb, input logic xsv,
                                input logic xer, input logic xem, input logic xhz,
                                input logic [31:0] xsd);
        vec_t v;
        v.ev = ev; v.ea = ea; v.ed = ed; v.eb = eb; v.sc = sc;
        v.lv = lv; v.la = la; v.lb = lb;
        v.xsv = xsv; v.xer = xer; v.xem = xem; v.xhz = xhz; v.xsd = xsd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                         input logic [3:0] eb, input logic sc, input logic lv,
                         input logic [31:0] la, input logic [3:0] lb);
        enqValid = ev; enqAddress = ea; enqData = ed; enqByteEnable = eb;
        storeComplete = sc;
        loadCheckValid = lv; loadCheckAddress = la; loadCheckByteEnable = lb;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare all outputs against the reference for the current cycle's inputs.
    task automatic model_check();
        logic        hit;
        int          yi;
        logic        fwd;
        logic        hz;
        logic [31:0] fdata;
        hit = 0; yi = 0; fwd = 0; fdata = 0;
        foreach (model[i]) begin
            if ((model[i].address[31:2] == loadCheckAddress[31:2]) &&
                ((model[i].byteEnable & loadCheckByteEnable) != 0)) begin
                hit = 1;
                yi  = i;
            end
        end
`ifdef STORE_FORWARD_EN
        fwd = loadCheckValid && hit &&
              ((model[yi].byteEnable & loadCheckByteEnable) == loadCheckByteEnable);
        if (fwd) fdata = model[yi].data;
`endif
        hz = loadCheckValid && hit && !fwd;
        chk("storeValid", 32'(storeValid), 32'(model.size() != 0));
        chk("enqReady", 32'(enqReady), 32'(model.size() < DEPTH));
        chk("bufferEmpty", 32'(bufferEmpty), 32'(model.size() == 0));
        chk("loadHazard", 32'(loadHazard), 32'(hz));
        chk("loadForwardValid", 32'(loadForwardValid), 32'(fwd));
        chk("loadForwardData", loadForwardData, fdata);
        if (model.size() != 0) begin
            chk("storeAddress", storeAddress, model[0].address);
            chk("storeData", storeData, model[0].data);
            chk("storeByteEnable", 32'(storeByteEnable), 32'(model[0].byteEnable));
        end
        if (enqValid && !overflowProbe)
            chk("protocol_enqReady", 32'(enqReady), 32'd1);
    endtask

    // Called #1 after the falling edge; checks, clocks, updates the reference.
    task automatic tick();
        logic doPush;
        logic doPop;
        storeBufferEntry_ e;
        model_check();
        doPush = enqValid && (model.size() < DEPTH);
        doPop  = storeComplete && (model.size() != 0);
        e.valid = 1'b1; e.address = enqAddress; e.data = enqData; e.byteEnable = enqByteEnable;
        @(posedge clock);
        if (reset) begin
            model.delete();
        end else begin
            if (doPop)  void'(model.pop_front());
            if (doPush) model.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic step();
        #1;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clock);
        step();
        step();
        reset = 1'b0;

        // Directed table: single sw drain, sb/lw overlap, pop-cycle hazard, same-cycle enqueue.
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 0, 0,         4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h1000,  32'hDEADBEEF, 4'hF, 0, 0, 0,       4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 0, 0,         4'h0, 1, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 0, 0,         4'h0, 1, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0,         0,          4'h0, 1, 0, 0,         4'h0, 1, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 0, 0,         4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h2001,  32'h0000AB00, 4'h2, 0, 0, 0,       4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 1, 32'h2000,  4'hF, 1, 1, 0, 1, 32'h0000AB00));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 1, 32'h2004,  4'hF, 1, 1, 0, 0, 32'h0000AB00));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 1, 32'h2000,  4'h1, 1, 1, 0, 0, 32'h0000AB00));
        vecs.push_back(mk(0, 0,         0,          4'h0, 1, 1, 32'h2000,  4'hF, 1, 1, 0, 1, 32'h0000AB00));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 1, 32'h2000,  4'hF, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h4000,  32'h12345678, 4'hF, 0, 1, 32'h4000, 4'hF, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0,         0,          4'h0, 1, 0, 0,         4'h0, 1, 1, 0, 0, 32'h12345678));
        vecs.push_back(mk(0, 0,         0,          4'h0, 0, 0, 0,         4'h0, 0, 1, 1, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].eb,
                  vecs[i].sc, vecs[i].lv, vecs[i].la, vecs[i].lb);
            #1;
            chk($sformatf("vec%0d_storeValid", i), 32'(storeValid), 32'(vecs[i].xsv));
            chk($sformatf("vec%0d_enqReady", i), 32'(enqReady), 32'(vecs[i].xer));
            chk($sformatf("vec%0d_bufferEmpty", i), 32'(bufferEmpty), 32'(vecs[i].xem));
            chk($sformatf("vec%0d_loadHazard", i), 32'(loadHazard), 32'(vecs[i].xhz));
            if (vecs[i].xsv)
                chk($sformatf("vec%0d_storeData", i), storeData, vecs[i].xsd);
            tick();
        end

        // Fill from a freshly reset buffer, refuse enqueue while full, then wrap the tail.
        reset = 1'b1; idle(); step(); reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h5000 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 0, 0, 0, 0);
            step();
        end
        idle();
        #1;
        chk("full_enqReady", 32'(enqReady), 32'd0);
        tick();
        overflowProbe = 1'b1;
        drive(1, 32'h5010, 32'hBB, 4'hF, 1, 0, 0, 0);
        #1;
        chk("full_pop_enqReady", 32'(enqReady), 32'd0);
        tick();
        overflowProbe = 1'b0;
        drive(1, 32'h5010, 32'hCC, 4'hF, 0, 0, 0, 0);
        #1;
        chk("after_pop_enqReady", 32'(enqReady), 32'd1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++) step();
        idle();
        #1;
        chk("wrap_tail_data", storeData, 32'hCC);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        step();
        idle();

        // Two stores to one word, then a full-word load of it.
        drive(1, 32'h3000, 32'h11223344, 4'hF, 0, 0, 0, 0); step();
        drive(1, 32'h3000, 32'h55667788, 4'hF, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 32'h3000, 4'hF);
        #1;
`ifdef STORE_FORWARD_EN
        chk("fwd_valid", 32'(loadForwardValid), 32'd1);
        chk("fwd_data", loadForwardData, 32'h55667788);
        chk("fwd_hazard", 32'(loadHazard), 32'd0);
`else
        chk("nofwd_valid", 32'(loadForwardValid), 32'd0);
        chk("nofwd_hazard", 32'(loadHazard), 32'd1);
`endif
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0); step(); step();

        // Reset with three entries held.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h7000 + 32'(4*i), 32'h70 + 32'(i), 4'hF, 0, 0, 0, 0);
            step();
        end
        reset = 1'b1; idle(); step(); reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 32'h7000, 4'hF);
        #1;
        chk("rst_storeValid", 32'(storeValid), 32'd0);
        chk("rst_bufferEmpty", 32'(bufferEmpty), 32'd1);
        chk("rst_loadHazard", 32'(loadHazard), 32'd0);
        tick();

        // Random traffic over a small address window so loads often collide.
        for (int n = 0; n < 400; n++) begin
            logic        ev;
            logic [31:0] ea;
            logic [31:0] la;
            logic [3:0]  eb;
            logic [3:0]  lb;
            ev = ($urandom_range(0, 1) == 1) && (model.size() < DEPTH);
            ea = 32'h6000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            la = 32'h6000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            eb = 4'($urandom_range(1, 15));
            lb = 4'($urandom_range(1, 15));
            drive(ev, ea, $urandom, eb, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, la, lb);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
